// File: rtl/four_bit_mux_arb_pkg.sv
// Shared definitions for the two-requester arbiter feeding a one-word output register.
// Holds the source encoding, the output-register state encoding and the winner selection rule.
package four_bit_mux_arb_pkg;

    localparam logic SRC_A = 1'b1;
    localparam logic SRC_B = 1'b0;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    // With both requesting, fair mode hands the grant to whoever did not win last time.
    function automatic logic pick_winner(
        input logic req_a,
        input logic req_b,
        input logic last_gnt,
        input logic fair
    );
        logic winner;
        if (req_a && req_b) begin
            if (fair && (last_gnt == SRC_A)) winner = SRC_B;
            else                             winner = SRC_A;
        end else if (req_a) begin
            winner = SRC_A;
        end else begin
            winner = SRC_B;
        end
        return winner;
    endfunction

endpackage

// File: rtl/four_bit_mux.sv
// Plain 2:1 mux for 4-bit words; sel=1 passes a, sel=0 passes b.
module four_bit_mux (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       sel,
    output logic [3:0] y
);

    assign y = sel ? a : b;

endmodule

// File: rtl/four_bit_mux_arb.sv
// Arbitrates requesters A and B onto a shared mux and captures the winning word in a
// one-entry output register with valid/ready handshake and per-source grant counters.
module four_bit_mux_arb
    import four_bit_mux_arb_pkg::*;
#(
    parameter bit FAIR = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req_a,
    input  logic [3:0] data_a,
    input  logic       req_b,
    input  logic [3:0] data_b,
    output logic       gnt_a,
    output logic       gnt_b,
    output logic       out_valid,
    output logic [3:0] out_data,
    output logic       out_src,
    input  logic       out_ready,
    output logic [7:0] cnt_a,
    output logic [7:0] cnt_b
);

    state_t     r_state;
    logic       r_last_gnt;
    logic       r_sel;
    logic [3:0] r_out_data;
    logic       r_out_src;
    logic [7:0] r_cnt_a;
    logic [7:0] r_cnt_b;

    logic       w_any_req;
    logic       w_accept;
    logic       w_winner;
    logic       w_sel;
    logic [3:0] w_mux_y;

    // A new word is taken whenever the register is free or is being drained this cycle.
    always_comb begin
        w_any_req = req_a | req_b;
        w_accept  = w_any_req & ((r_state == EMPTY) | out_ready) & rst_n;
        w_winner  = pick_winner(req_a, req_b, r_last_gnt, FAIR);
        w_sel     = w_any_req ? w_winner : r_sel;
    end

    assign gnt_a = w_accept & (w_winner == SRC_A);
    assign gnt_b = w_accept & (w_winner == SRC_B);

    four_bit_mux u_mux (
        .a   (data_a),
        .b   (data_b),
        .sel (w_sel),
        .y   (w_mux_y)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= EMPTY;
            r_last_gnt <= SRC_B;
            r_sel      <= 1'b0;
            r_out_data <= 4'h0;
            r_out_src  <= 1'b0;
            r_cnt_a    <= 8'd0;
            r_cnt_b    <= 8'd0;
        end else begin
            r_sel <= w_sel;
            if (w_accept) begin
                r_state    <= FULL;
                r_out_data <= w_mux_y;
                r_out_src  <= w_winner;
                r_last_gnt <= w_winner;
            end else if (out_ready) begin
                r_state <= EMPTY;
            end
            // Counters wrap naturally at 8 bits.
            r_cnt_a <= r_cnt_a + {7'd0, gnt_a};
            r_cnt_b <= r_cnt_b + {7'd0, gnt_b};
        end
    end

    assign out_valid = (r_state == FULL);
    assign out_data  = r_out_data;
    assign out_src   = r_out_src;
    assign cnt_a     = r_cnt_a;
    assign cnt_b     = r_cnt_b;

endmodule

// File: tb/tb_four_bit_mux_arb.sv
// Drives a fair and a fixed-priority arbiter with the same directed vectors and checks both
// against a transaction-level model every cycle, plus hand-computed checkpoints.
module tb_four_bit_mux_arb;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b1;
    logic       reqA  = 1'b0;
    logic [3:0] dataA = 4'h0;
    logic       reqB  = 1'b0;
    logic [3:0] dataB = 4'h0;
    logic       outReady = 1'b0;

    logic [1:0]      gntA;
    logic [1:0]      gntB;
    logic [1:0]      oValid;
    logic [1:0]      oSrc;
    logic [1:0][3:0] oData;
    logic [1:0][7:0] cntA;
    logic [1:0][7:0] cntB;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    four_bit_mux_arb #(.FAIR(1'b1)) dutFair (
        .clk(clk), .rst_n(rst_n),
        .req_a(reqA), .data_a(dataA), .req_b(reqB), .data_b(dataB),
        .gnt_a(gntA[0]), .gnt_b(gntB[0]),
        .out_valid(oValid[0]), .out_data(oData[0]), .out_src(oSrc[0]),
        .out_ready(outReady), .cnt_a(cntA[0]), .cnt_b(cntB[0])
    );

    four_bit_mux_arb #(.FAIR(1'b0)) dutFixed (
        .clk(clk), .rst_n(rst_n),
        .req_a(reqA), .data_a(dataA), .req_b(reqB), .data_b(dataB),
        .gnt_a(gntA[1]), .gnt_b(gntB[1]),
        .out_valid(oValid[1]), .out_data(oData[1]), .out_src(oSrc[1]),
        .out_ready(outReady), .cnt_a(cntA[1]), .cnt_b(cntB[1])
    );

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    // Inputs change just after a rising edge and stay put for the whole cycle.
    task automatic applyStimulus(input logic ra, input logic [3:0] da,
                                 input logic rb, input logic [3:0] db, input logic rdy);
        @(posedge clk);
        #1;
        reqA = ra; dataA = da; reqB = rb; dataB = db; outReady = rdy;
    endtask

    task automatic sampleNow();
        @(negedge clk);
        #1;
    endtask

    task automatic doReset();
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        reqA = 1'b0; dataA = 4'h0; reqB = 1'b0; dataB = 4'h0; outReady = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    // Transaction-level model: index 0 is the fair arbiter, index 1 the fixed-priority one.
    int  mValid[2];
    int  mData[2];
    int  mSrc[2];
    int  mCntA[2];
    int  mCntB[2];
    int  mLastWasA[2];

    initial begin
        forever begin
            @(negedge clk);
            for (int i = 0; i < 2; i++) begin
                int anyReq, accept, winA, expGa, expGb;
                if (!rst_n) begin
                    mValid[i] = 0; mData[i] = 0; mSrc[i] = 0;
                    mCntA[i] = 0; mCntB[i] = 0; mLastWasA[i] = 0;
                end
                anyReq = (reqA || reqB) ? 1 : 0;
                accept = (rst_n && anyReq && (mValid[i] == 0 || outReady)) ? 1 : 0;
                if (reqA && reqB) winA = (i == 0) ? (mLastWasA[i] ? 0 : 1) : 1;
                else              winA = reqA ? 1 : 0;
                expGa = accept & winA;
                expGb = accept & (1 - winA);

                checkOutput($sformatf("gnt_a[%0d]", i), int'(gntA[i]), expGa);
                checkOutput($sformatf("gnt_b[%0d]", i), int'(gntB[i]), expGb);
                checkOutput($sformatf("out_valid[%0d]", i), int'(oValid[i]), mValid[i]);
                checkOutput($sformatf("out_data[%0d]", i), int'(oData[i]), mData[i]);
                checkOutput($sformatf("out_src[%0d]", i), int'(oSrc[i]), mSrc[i]);
                checkOutput($sformatf("cnt_a[%0d]", i), int'(cntA[i]), mCntA[i]);
                checkOutput($sformatf("cnt_b[%0d]", i), int'(cntB[i]), mCntB[i]);

                if (rst_n) begin
                    if (accept) begin
                        mValid[i]    = 1;
                        mData[i]     = winA ? int'(dataA) : int'(dataB);
                        mSrc[i]      = winA;
                        mLastWasA[i] = winA;
                        if (winA) mCntA[i] = (mCntA[i] + 1) % 256;
                        else      mCntB[i] = (mCntB[i] + 1) % 256;
                    end else if (outReady) begin
                        mValid[i] = 0;
                    end
                end
            end
        end
    end

    typedef struct {
        logic       ra;
        logic [3:0] da;
        logic       rb;
        logic [3:0] db;
        logic       rdy;
    } vec_t;

    vec_t mixVecs[12];

    initial begin
        mixVecs[0]  = '{1'b1, 4'h1, 1'b0, 4'h0, 1'b0};
        mixVecs[1]  = '{1'b1, 4'h2, 1'b1, 4'hE, 1'b0};
        mixVecs[2]  = '{1'b1, 4'h2, 1'b1, 4'hE, 1'b1};
        mixVecs[3]  = '{1'b1, 4'h4, 1'b1, 4'hE, 1'b1};
        mixVecs[4]  = '{1'b0, 4'h0, 1'b1, 4'hD, 1'b1};
        mixVecs[5]  = '{1'b0, 4'h0, 1'b0, 4'h0, 1'b0};
        mixVecs[6]  = '{1'b0, 4'h0, 1'b0, 4'h0, 1'b1};
        mixVecs[7]  = '{1'b0, 4'h0, 1'b0, 4'h0, 1'b1};
        mixVecs[8]  = '{1'b1, 4'hF, 1'b1, 4'h8, 1'b0};
        mixVecs[9]  = '{1'b1, 4'h6, 1'b1, 4'h8, 1'b1};
        mixVecs[10] = '{1'b1, 4'h6, 1'b1, 4'h8, 1'b1};
        mixVecs[11] = '{1'b0, 4'h0, 1'b0, 4'h0, 1'b1};
    end

    initial begin
        #1 rst_n = 1'b0;
        sampleNow();
        checkOutput("reset out_valid", int'(oValid[0]), 0);
        checkOutput("reset cnt_a", int'(cntA[0]), 0);

        // Single A request from reset: same-cycle grant, registered word one cycle later.
        doReset();
        applyStimulus(1'b1, 4'h5, 1'b0, 4'h0, 1'b1);
        sampleNow();
        checkOutput("first gnt_a", int'(gntA[0]), 1);
        checkOutput("first out_valid before edge", int'(oValid[0]), 0);
        applyStimulus(1'b0, 4'h0, 1'b0, 4'h0, 1'b1);
        sampleNow();
        checkOutput("first out_valid", int'(oValid[0]), 1);
        checkOutput("first out_data", int'(oData[0]), 5);
        checkOutput("first out_src", int'(oSrc[0]), 1);
        checkOutput("first cnt_a", int'(cntA[0]), 1);

        // Continuous contention: fair alternates A,B,A,B; fixed always grants A.
        doReset();
        for (int k = 0; k < 5; k++) begin
            applyStimulus(1'b1, 4'h3, 1'b1, 4'hC, 1'b1);
            sampleNow();
            checkOutput($sformatf("fair gnt_a k=%0d", k), int'(gntA[0]), (k % 2 == 0) ? 1 : 0);
            checkOutput($sformatf("fixed gnt_a k=%0d", k), int'(gntA[1]), 1);
            checkOutput($sformatf("fixed gnt_b k=%0d", k), int'(gntB[1]), 0);
            if (k > 0) begin
                checkOutput($sformatf("fair out_data k=%0d", k), int'(oData[0]), (k % 2 == 1) ? 3 : 12);
                checkOutput($sformatf("fixed out_data k=%0d", k), int'(oData[1]), 3);
            end
        end

        // Stalled output: B must wait until the consumer is ready again.
        doReset();
        applyStimulus(1'b0, 4'h0, 1'b1, 4'h9, 1'b1);
        sampleNow();
        checkOutput("stall first gnt_b", int'(gntB[0]), 1);
        for (int k = 0; k < 3; k++) begin
            applyStimulus(1'b0, 4'h0, 1'b1, 4'hA, 1'b0);
            sampleNow();
            checkOutput($sformatf("stall gnt_b k=%0d", k), int'(gntB[0]), 0);
            checkOutput($sformatf("stall out_data k=%0d", k), int'(oData[0]), 9);
            checkOutput($sformatf("stall out_valid k=%0d", k), int'(oValid[0]), 1);
        end
        applyStimulus(1'b0, 4'h0, 1'b1, 4'hA, 1'b1);
        sampleNow();
        checkOutput("stall release gnt_b", int'(gntB[0]), 1);
        applyStimulus(1'b0, 4'h0, 1'b0, 4'h0, 1'b1);
        sampleNow();
        checkOutput("stall release out_data", int'(oData[0]), 10);
        checkOutput("stall cnt_b", int'(cntB[0]), 2);

        // Counter wrap after 256 back-to-back A grants.
        doReset();
        for (int k = 0; k < 256; k++) begin
            applyStimulus(1'b1, 4'(k), 1'b0, 4'h0, 1'b1);
        end
        applyStimulus(1'b0, 4'h0, 1'b0, 4'h0, 1'b1);
        sampleNow();
        checkOutput("wrap cnt_a fair", int'(cntA[0]), 0);
        checkOutput("wrap cnt_a fixed", int'(cntA[1]), 0);
        checkOutput("wrap out_data", int'(oData[0]), 15);
        applyStimulus(1'b0, 4'h0, 1'b0, 4'h0, 1'b1);
        sampleNow();
        checkOutput("drain out_valid", int'(oValid[0]), 0);

        // Mixed directed vectors, checked by the model alone.
        doReset();
        foreach (mixVecs[k]) begin
            applyStimulus(mixVecs[k].ra, mixVecs[k].da, mixVecs[k].rb, mixVecs[k].db, mixVecs[k].rdy);
        end

        // Asynchronous reset while FULL, after A won most recently.
        doReset();
        applyStimulus(1'b1, 4'h7, 1'b0, 4'h0, 1'b1);
        @(posedge clk);
        #1;
        checkOutput("pre-reset out_valid", int'(oValid[0]), 1);
        rst_n = 1'b0;
        reqA = 1'b1; reqB = 1'b1; dataB = 4'hC;
        #1;
        checkOutput("async reset out_valid", int'(oValid[0]), 0);
        checkOutput("reset gnt_a", int'(gntA[0]), 0);
        checkOutput("reset gnt_b", int'(gntB[0]), 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        outReady = 1'b0;
        sampleNow();
        checkOutput("post-reset contention gnt_a", int'(gntA[0]), 1);
        checkOutput("post-reset contention gnt_b", int'(gntB[0]), 0);
        applyStimulus(1'b0, 4'h0, 1'b0, 4'h0, 1'b1);
        sampleNow();
        checkOutput("post-reset out_data", int'(oData[0]), 7);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/four_bit_mux_arb.md
FOUR_BIT_MUX_ARB -- requirements
Module: four_bit_mux_arb

Interface
REQ-001 Parameter FAIR, default 1: 1 selects round-robin arbitration, 0 selects fixed priority with A always winning.
REQ-002 clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 rst_n  input  1  reset, asynchronous and active-low.
REQ-004 req_a  input  1  requester A holds a 4-bit word for transfer.
REQ-005 data_a  input  4  requester A word; held stable while req_a=1 and gnt_a=0.
REQ-006 req_b  input  1  requester B holds a 4-bit word for transfer.
REQ-007 data_b  input  4  requester B word; held stable while req_b=1 and gnt_b=0.
REQ-008 gnt_a  output  1  combinational one-cycle pulse: A's word is accepted this cycle.
REQ-009 gnt_b  output  1  combinational one-cycle pulse: B's word is accepted this cycle.
REQ-010 out_valid  output  1  registered; out_data and out_src hold a valid word.
REQ-011 out_data  output  4  registered word taken from the shared mux output.
REQ-012 out_src  output  1  registered source of out_data: 1=A, 0=B.
REQ-013 out_ready  input  1  downstream consumer accepts the word when out_valid=1 and out_ready=1.
REQ-014 cnt_a  output  8  registered count of A grants, wrapping 255->0.
REQ-015 cnt_b  output  8  registered count of B grants, wrapping 255->0.

Function
REQ-016 The block has two states: EMPTY (out_valid=0) and FULL (out_valid=1).
REQ-017 accept = (req_a | req_b) & (EMPTY | out_ready); at most one of gnt_a/gnt_b is 1, and both are 0 when accept=0.
REQ-018 When only one requester is active, that requester wins.
REQ-019 When both are active and FAIR=1, the winner is the requester not granted most recently (last_gnt pointer); when FAIR=0, A wins.
REQ-020 last_gnt updates only on accept, to the winner.
REQ-021 The mux select drives sel=1 for A and sel=0 for B; on accept, out_data<=mux y, out_src<=winner, and out_valid<=1 at the next edge (latency 1 cycle).
REQ-022 EMPTY->FULL on accept; FULL->EMPTY on out_ready with no accept; FULL->FULL on out_ready with accept (back-to-back transfer, one word per cycle).
REQ-023 FULL with out_ready=0: no grant; out_data, out_src and out_valid hold unchanged.
REQ-024 cnt_a/cnt_b increment by 1 on the cycle after gnt_a/gnt_b; neither counter saturates.
REQ-025 When no requester is active, the mux select holds its previous value.

Reset
REQ-026 When rst_n=0: out_valid=0, out_data=4'h0, out_src=0, cnt_a=cnt_b=0, last_gnt=B (A wins the first contention), sel=0; state EMPTY.
REQ-027 Reset asserted mid-transfer discards any held word; gnt_a/gnt_b are 0 while rst_n=0.

Structure
REQ-028 The existing four_bit_mux is the single sub-module, instantiated as the shared datapath (ports a, b, sel, y).
REQ-029 A shared package holds the source encoding constants (SRC_A=1, SRC_B=0) and the state encoding (EMPTY, FULL).

Verification
REQ-030 Reset release, req_a=1 data_a=4'h5, out_ready=1 -> gnt_a pulses the same cycle; the next cycle gives out_valid=1, out_data=5, out_src=1, and cnt_a=1.
REQ-031 Both requesting continuously (A=4'h3, B=4'hC), FAIR=1, out_ready=1 -> grants alternate A,B,A,B and out_data sequence is 3,C,3,C.
REQ-032 Same stimulus with FAIR=0 -> gnt_a every cycle, gnt_b never; out_data stays 3.
REQ-033 FULL with out_ready=0 for 3 cycles and req_b=1 -> no gnt_b; out_data is held; on out_ready=1, gnt_b fires the same cycle.
REQ-034 256 consecutive A grants -> cnt_a returns to 0.
REQ-035 rst_n low for 1 cycle while FULL -> out_valid=0 immediately (asynchronous); the next contention is won by A.
